// File: rtl/mem_acs_stg_ws.sv
// mem_acs_stg_ws: MEM pipeline stage with byte-addressed little-endian data memory,
// programmable wait states with upstream stall, and misaligned word-access detection.
module mem_acs_stg_ws #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 256,
    parameter int RFA   = 3,
    parameter int WAIT  = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           mem_modif,
    input  logic           wr_rd_enable,
    input  logic           acc_word,
    input  logic           sign_ext,
    input  logic [AW-1:0]  d_addr,
    input  logic [DW-1:0]  d_wr_data,
    input  logic [DW-1:0]  alu_res,
    input  logic           write_bin,
    input  logic [RFA-1:0] rf_writea_min,
    output logic           stall,
    output logic           out_valid,
    output logic [DW-1:0]  wb_data,
    output logic           write_bout,
    output logic [RFA-1:0] rf_writea_mout,
    output logic           misalign_err
);
    localparam int NB  = DW / 8;
    localparam int LNB = $clog2(NB);
    localparam int DA  = $clog2(DEPTH);
    localparam logic [3:0] WL = 4'(WAIT > 0 ? WAIT - 1 : 0);

    typedef enum logic {IDLE, WAITST} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [7:0]    mem_q [DEPTH];
    logic [DA-1:0] ea;
    logic          acc, mis, unused_addr;
    logic [DW-1:0] rword, rdata;

    always_comb begin
        ea          = d_addr[DA-1:0];
        unused_addr = ^d_addr;
        acc         = in_valid & mem_modif;
        mis         = acc & acc_word & (ea[LNB-1:0] != '0);
        stall       = (WAIT > 0) && acc && (state_q == IDLE || cnt_q != '0);
        rword       = '0;
        for (int i = 0; i < NB; i++) rword[8*i +: 8] = mem_q[ea + DA'(i)];
        // byte loads take the addressed byte and extend from its bit 7
        rdata       = acc_word ? rword : {{(DW-8){sign_ext & rword[7]}}, rword[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            out_valid      <= 1'b0;
            write_bout     <= 1'b0;
            misalign_err   <= 1'b0;
            wb_data        <= '0;
            rf_writea_mout <= '0;
        end else if (stall) begin
            out_valid    <= 1'b0;
            write_bout   <= 1'b0;
            misalign_err <= 1'b0;
            state_q      <= WAITST;
            cnt_q        <= (state_q == IDLE) ? WL : cnt_q - 4'd1;
        end else begin
            state_q        <= IDLE;
            out_valid      <= in_valid;
            write_bout     <= in_valid & write_bin & ~mis;
            misalign_err   <= mis;
            rf_writea_mout <= rf_writea_min;
            wb_data        <= mis ? '0 : (acc && !wr_rd_enable) ? rdata : alu_res;
            for (int i = 0; i < NB; i++)
                if (acc && wr_rd_enable && !mis && (acc_word || i == 0))
                    mem_q[ea + DA'(i)] <= d_wr_data[8*i +: 8];
        end
    end
endmodule
